// File: rtl/route_sw_scheduler.sv
// Rotating make-before-break capacitor window for the route distributor.
// Keeps CHANNEL_NUM contiguous enables and steps the window one slot.
module route_sw_scheduler #(
  parameter int CHANNEL_NUM   = 14,
  parameter int CAPACITOR_NUM = 16,
  parameter int DWELL_W       = 16,
  parameter int BASE_W        = $clog2(CAPACITOR_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic [7:0]               settle,
  input  logic                     req,
  output logic [CAPACITOR_NUM-1:0] sw,
  output logic [BASE_W-1:0]        base,
  output logic                     busy,
  output logic                     rot_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_MAKE,
    S_BREAK
  } state_t;

  function automatic logic [CAPACITOR_NUM-1:0] rst_win();
    logic [CAPACITOR_NUM-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) v[i] = 1'b1;
    return v;
  endfunction

  localparam logic [CAPACITOR_NUM-1:0] SW_RST = rst_win();
  localparam logic [BASE_W:0] CH_W = (BASE_W+1)'(CHANNEL_NUM);
  localparam logic [BASE_W:0] CAP_W = (BASE_W+1)'(CAPACITOR_NUM);
  localparam logic [BASE_W-1:0] BASE_MAX = BASE_W'(CAPACITOR_NUM - 1);

  state_t                   state;
  state_t                   state_n;
  logic [DWELL_W-1:0]       dwell_cnt;
  logic [DWELL_W-1:0]       dwell_n;
  logic [DWELL_W-1:0]       dwell_inc;
  logic [7:0]               settle_cnt;
  logic [7:0]               settle_n;
  logic [CAPACITOR_NUM-1:0] sw_n;
  logic [BASE_W-1:0]        base_n;
  logic [BASE_W-1:0]        base_inc;
  logic [BASE_W:0]          make_sum;
  logic [BASE_W-1:0]        make_idx;
  logic                     dwell_hit;
  logic                     trig;

  // Slot just above the window, wrapped modulo the capacitor count.
  assign make_sum = {1'b0, base} + CH_W;
  assign make_idx = (make_sum >= CAP_W) ?
                    BASE_W'(make_sum - CAP_W) :
                    make_sum[BASE_W-1:0];
  assign base_inc = (base == BASE_MAX) ? '0 : base + BASE_W'(1);

  // Saturate so a long dwell=0 stretch cannot wrap and misfire later.
  assign dwell_inc = (&dwell_cnt) ? dwell_cnt : dwell_cnt + DWELL_W'(1);
  assign dwell_hit = (dwell != '0) &&
                     (dwell_cnt >= dwell - DWELL_W'(1));
  assign trig      = req || dwell_hit;

  always_comb begin
    state_n  = state;
    sw_n     = sw;
    base_n   = base;
    dwell_n  = dwell_cnt;
    settle_n = settle_cnt;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_HOLD;
          dwell_n = '0;
        end
      end
      S_HOLD: begin
        dwell_n = dwell_inc;
        if (trig) begin
          state_n        = S_MAKE;
          sw_n[make_idx] = 1'b1;
          settle_n       = '0;
        end else if (!en) begin
          state_n = S_IDLE;
        end
      end
      S_MAKE: begin
        if (settle_cnt == settle) begin
          state_n    = S_BREAK;
          sw_n[base] = 1'b0;
          base_n     = base_inc;
        end else begin
          settle_n = settle_cnt + 8'd1;
        end
      end
      S_BREAK: begin
        dwell_n = '0;
        state_n = en ? S_HOLD : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sw         <= SW_RST;
      base       <= '0;
      dwell_cnt  <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      rot_done   <= 1'b0;
    end else begin
      state      <= state_n;
      sw         <= sw_n;
      base       <= base_n;
      dwell_cnt  <= dwell_n;
      settle_cnt <= settle_n;
      busy       <= (state_n == S_MAKE) || (state_n == S_BREAK);
      rot_done   <= (state_n == S_BREAK);
    end
  end

endmodule

// File: tb/tb_route_sw_scheduler.sv
// Directed bench for route_sw_scheduler with 14-of-16 window.
// Inputs change after negedge; outputs are sampled at negedge.
module tb_route_sw_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] dwell = '0;
  logic [7:0]  settle = '0;
  logic        req = 1'b0;
  logic [15:0] sw;
  logic [3:0]  base;
  logic        busy;
  logic        rot_done;

  int checks = 0;
  int errors = 0;

  route_sw_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dwell    (dwell),
    .settle   (settle),
    .req      (req),
    .sw       (sw),
    .base     (base),
    .busy     (busy),
    .rot_done (rot_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic look(input string tag, input logic [15:0] e_sw,
                      input logic [3:0] e_base, input logic e_busy,
                      input logic e_done);
    check({tag, ".sw"}, 32'(sw), 32'(e_sw));
    check({tag, ".base"}, 32'(base), 32'(e_base));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".rot_done"}, 32'(rot_done), 32'(e_done));
  endtask

  // Reset lands mid-cycle, so outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    en  = 1'b0;
    req = 1'b0;
    #1 look(tag, 16'h3FFF, 4'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] win(input int b);
    logic [31:0] w;
    w = 32'h3FFF << (b % 16);
    return w[15:0] | w[31:16];
  endfunction

  initial begin
    logic [15:0] e_sw;
    logic [3:0]  e_base;
    logic        e_busy;
    logic        e_done;
    int          p;
    int          r;

    do_reset("reset");

    // en high, dwell 0: never rotates on its own
    en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      check("idle_sw", 32'(sw), 32'h3FFF);
      check("idle_busy", 32'(busy), 32'h0);
    end
    check("idle_base", 32'(base), 32'h0);

    // single req, settle 0
    req = 1'b1;
    tick();
    req = 1'b0;
    look("req_make", 16'h7FFF, 4'd0, 1'b1, 1'b0);
    tick();
    look("req_break", 16'h7FFE, 4'd1, 1'b1, 1'b1);
    tick();
    look("req_hold", 16'h7FFE, 4'd1, 1'b0, 1'b0);

    // 16 automatic rotations: dwell 10, settle 3, period 15
    do_reset("reset2");
    en     = 1'b1;
    dwell  = 16'd10;
    settle = 8'd3;
    for (int t = 1; t <= 250; t++) begin
      tick();
      if (t < 11) begin
        e_sw = 16'h3FFF; e_base = 4'd0; e_busy = 1'b0; e_done = 1'b0;
      end else begin
        p = (t - 11) % 15;
        r = (t - 11) / 15;
        if (p < 4) begin
          e_sw   = win(r) | (16'h1 << ((r + 14) % 16));
          e_base = 4'(r);
          e_busy = 1'b1;
          e_done = 1'b0;
        end else begin
          e_sw   = win(r + 1);
          e_base = 4'((r + 1) % 16);
          e_busy = (p == 4);
          e_done = (p == 4);
        end
      end
      look($sformatf("auto_t%0d", t), e_sw, e_base, e_busy, e_done);
      if (t == 11 + 15 * 2 - 1)
        check("wrap_pre", 32'(sw), 32'hFFFC);
      if (t == 11 + 15 * 2)
        check("wrap_make", 32'(sw), 32'hFFFD);
      if (t == 11 + 15 * 2 + 4)
        check("wrap_break", 32'(sw), 32'hFFF9);
    end
    check("auto_end_sw", 32'(sw), 32'h3FFF);
    dwell = 16'd0;

    // req mid-MAKE is dropped
    req = 1'b1;
    tick();
    req = 1'b0;
    look("mm_make", 16'h7FFF, 4'd0, 1'b1, 1'b0);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    look("mm_make2", 16'h7FFF, 4'd0, 1'b1, 1'b0);
    tick();
    tick();
    look("mm_break", 16'h7FFE, 4'd1, 1'b1, 1'b1);
    tick();
    look("mm_hold", 16'h7FFE, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      look("mm_quiet", 16'h7FFE, 4'd1, 1'b0, 1'b0);
    end

    // req together with dwell expiry: one rotation
    dwell  = 16'd3;
    settle = 8'd0;
    req    = 1'b1;
    tick();
    req = 1'b0;
    look("co_make", 16'hFFFE, 4'd1, 1'b1, 1'b0);
    tick();
    look("co_break", 16'hFFFC, 4'd2, 1'b1, 1'b1);
    tick();
    look("co_hold0", 16'hFFFC, 4'd2, 1'b0, 1'b0);
    tick();
    look("co_hold1", 16'hFFFC, 4'd2, 1'b0, 1'b0);
    tick();
    look("co_hold2", 16'hFFFC, 4'd2, 1'b0, 1'b0);
    dwell = 16'd0;
    tick();
    look("co_hold3", 16'hFFFC, 4'd2, 1'b0, 1'b0);

    // en dropped right after the trigger
    do_reset("reset3");
    en = 1'b1;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    en  = 1'b0;
    look("en_make", 16'h7FFF, 4'd0, 1'b1, 1'b0);
    tick();
    look("en_break", 16'h7FFE, 4'd1, 1'b1, 1'b1);
    tick();
    look("en_idle", 16'h7FFE, 4'd1, 1'b0, 1'b0);
    req   = 1'b1;
    dwell = 16'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      look("en_ignored", 16'h7FFE, 4'd1, 1'b0, 1'b0);
    end
    req   = 1'b0;
    dwell = 16'd0;

    // async reset in the middle of MAKE
    do_reset("reset4");
    en     = 1'b1;
    settle = 8'd5;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    look("rm_make", 16'h7FFF, 4'd0, 1'b1, 1'b0);
    tick();
    look("rm_make2", 16'h7FFF, 4'd0, 1'b1, 1'b0);
    do_reset("rm_reset");
    tick();
    look("rm_after", 16'h3FFF, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
